ring_rotate_ctrl: RTL
=====================

Name: ring_rotate_ctrl

Overview:
- Command-driven controller that holds a DEPTH-entry register ring.
- Optionally loads the ring from an input stream, rotates it a commanded number of steps, then drains it on an output stream.
- It is the loader/sequencer stage that feeds and consumes the register-rotation datapath.
- Rotation uses true simultaneous-shift semantics: all entries update from pre-edge values in the same cycle.

Parameters:
- W, 2, data width of each ring entry.
- DEPTH, 3, number of ring entries (≥2).
- CW, 4, width of the rotate-count command.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- cmd_start  input  1  start-command strobe; sampled only in IDLE.
- cmd_load  input  1  1 = load DEPTH words before rotating; 0 = rotate current contents.
- cmd_dir  input  1  0 = rotate up (r[0]<=r[DEPTH-1], r[i]<=r[i-1]); 1 = rotate down (r[DEPTH-1]<=r[0], r[i]<=r[i+1]).
- cmd_rot  input  CW  number of single-step rotations.
- in_valid  input  1  load data valid.
- in_data  input  W  load data word.
- in_ready  output  1  high only in LOAD.
- out_valid  output  1  high only in DRAIN.
- out_data  output  W  drained entry r[idx].
- out_ready  input  1  downstream accept.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final output word is accepted.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; r[i]=(i+1) truncated to W (default ring 1,2,3).
  - idx=0, rotation counter=0.
  - in_ready, out_valid, busy, done = 0; out_data=0.
- Reset asserted mid-operation aborts immediately to the same values; no partial output completes.
- IDLE:
  - On cmd_start=1, latch cmd_load, cmd_dir, cmd_rot.
  - Next state: LOAD if cmd_load=1; else ROTATE if cmd_rot!=0; else DRAIN.
  - cmd_start while not IDLE is ignored; latched commands do not change mid-operation.
- LOAD:
  - in_ready=1; each cycle with in_valid=1 writes in_data to r[idx], idx++.
  - in_valid=0 cycles stall without any state change.
  - After r[DEPTH-1] is written: idx=0; go to ROTATE if latched rot!=0, else DRAIN.
- ROTATE:
  - Exactly one ring step per cycle in the latched direction; counter counts latched rot steps.
  - Takes exactly rot cycles, then goes to DRAIN with idx=0.
  - Steps are not reduced modulo DEPTH; rot=DEPTH leaves the contents unchanged but still takes DEPTH cycles.
- DRAIN:
  - out_valid=1, out_data=r[idx] (combinational from idx).
  - On out_valid&&out_ready, idx++.
  - out_data holds stable while out_ready=0.
  - After r[DEPTH-1] is accepted: done=1 for the following cycle, state=IDLE, idx=0. Ring contents are retained for the next command.
- Latency:
  - cmd_start to first out_valid = 1 (IDLE) + DEPTH load beats (if loading) + rot cycles.
  - Example: no load, rot=0 → out_valid in the cycle after the start edge.
- A start accepted on the same edge that done is asserted is not possible: done asserts while the state is already IDLE. A cmd_start in that done cycle is accepted normally.
- All state is held in registers; the ring update uses nonblocking semantics (no order dependence between entries).

Test Plan:
- Reset pattern: release rst; cmd_start, load=0, rot=1, dir=0 → busy next cycle; after 1 ROTATE cycle, drain 3,1,2; done pulses once; busy=0.
- Load with no rotation: load=1, rot=0; feed 0,1,2 with in_valid gaps of 2 cycles → in_ready high throughout LOAD; drain 0,1,2; ring retains 0,1,2.
- Down rotation with wrap: ring 1,2,3; load=0, dir=1, rot=4 → exactly 4 ROTATE cycles; drain 2,3,1.
- Backpressure: during DRAIN hold out_ready=0 for 5 cycles on word 2 → out_valid=1 and out_data stable for all 5 cycles; no skip or duplicate; done only after the last accept.
- Reset mid-ROTATE: load=0, rot=10; drop rst at ROTATE cycle 3 → immediately busy=0, out_valid=0, ring=1,2,3; next command behaves as from a fresh reset.
- Ignored start: pulse cmd_start with different fields during LOAD and DRAIN → no effect on the latched rot/dir or the sequence; done pulses exactly once.

Source files
------------

// File: rtl/ring_rotate_ctrl.sv
// ring_rotate_ctrl: command-driven loader/sequencer around a DEPTH-entry
// register ring. A command optionally loads the ring from an input stream,
// rotates it a given number of single steps, then drains it in index order.
//
// Handshakes: a word moves on in_* when in_valid && in_ready at a rising
// edge, and on out_* when out_valid && out_ready at a rising edge. in_ready
// is high only in LOAD and out_valid only in DRAIN. out_data depends only on
// registered state, so it stays stable while the consumer stalls.
module ring_rotate_ctrl #(
  parameter int W     = 2,
  parameter int DEPTH = 3,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_load,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_rot,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  ring [DEPTH];
  logic [IW-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] rot_q;
  logic          dir_q;
  logic          done_q, done_d;
  logic          load_we;
  logic          rot_step;
  logic          cmd_take;

  // Next-state, index/counter updates and handshake outputs.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    done_d    = 1'b0;
    load_we   = 1'b0;
    rot_step  = 1'b0;
    cmd_take  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          cmd_take = 1'b1;
          idx_d    = '0;
          cnt_d    = '0;
          if (cmd_load)            state_d = LOAD;
          else if (cmd_rot != '0)  state_d = ROTATE;
          else                     state_d = DRAIN;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = (rot_q != '0) ? ROTATE : DRAIN;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      ROTATE: begin
        // One ring step every cycle; the count is never folded modulo DEPTH.
        rot_step = 1'b1;
        if (cnt == rot_q - CW'(1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = ring[idx];
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, ring index, rotation counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      done_q <= done_d;
    end
  end

  // Command fields are captured only when a start is taken in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q <= '0;
      dir_q <= 1'b0;
    end else if (cmd_take) begin
      rot_q <= cmd_rot;
      dir_q <= cmd_dir;
    end
  end

  // Ring storage: load writes one entry, rotation shifts all entries at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= W'(i + 1);
    end else if (load_we) begin
      ring[idx] <= in_data;
    end else if (rot_step) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!dir_q) ring[i] <= ring[(i + DEPTH - 1) % DEPTH];
        else        ring[i] <= ring[(i + 1) % DEPTH];
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule
